// File: rtl/alu16_reg_if.sv
// alu16_reg_if: operand/result bundle for the registered ALU stage.
//
// Signals:
//   inM, inN  operands                   (master -> slave)
//   opc       operation select           (master -> slave)
//   inC       carry/borrow/shift-in bit  (master -> slave)
//   outF      registered result          (slave -> master)
//   zer       registered zero flag       (slave -> master)
//   neg       registered negative flag   (slave -> master)
//   co        registered carry/borrow    (slave -> master)
//
// Handshake: there is none. Every rising clk edge accepts the operands
// present at that edge, and the result shows up one cycle later. There is
// no valid/ready pair and no stall.
interface alu16_reg_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] inM;
    logic [WIDTH-1:0] inN;
    logic [2:0]       opc;
    logic             inC;
    logic [WIDTH-1:0] outF;
    logic             zer;
    logic             neg;
    logic             co;

    modport master (
        output inM, inN, opc, inC,
        input  outF, zer, neg, co
    );

    modport slave (
        input  inM, inN, opc, inC,
        output outF, zer, neg, co
    );
endinterface

// File: rtl/alu16_reg.sv
// alu16_reg: registered arithmetic/logic unit with a 3-bit opcode and carry-in.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    alu16_reg_if slave modport (operands in, registered result/flags out)
//
// Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT, 110 SHL,
// 111 reserved (result 0). Latency is exactly one cycle, and all outputs
// are registered.
module alu16_reg #(
    parameter int WIDTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    alu16_reg_if.slave   bus
);
    logic [WIDTH:0]   sumExt;
    logic [WIDTH:0]   diffExt;
    logic [WIDTH:0]   cinExt;
    logic [WIDTH-1:0] nextF;
    logic             nextCo;

    assign cinExt = {{WIDTH{1'b0}}, bus.inC};

    // One extra bit holds the carry. For the difference, that bit is the
    // borrow, because it is set exactly when M < N + inC.
    assign sumExt  = {1'b0, bus.inM} + {1'b0, bus.inN} + cinExt;
    assign diffExt = {1'b0, bus.inM} - {1'b0, bus.inN} - cinExt;

    always_comb begin
        nextF  = '0;
        nextCo = 1'b0;
        case (bus.opc)
            3'b000: begin
                nextF  = sumExt[WIDTH-1:0];
                nextCo = sumExt[WIDTH];
            end
            3'b001: begin
                nextF  = diffExt[WIDTH-1:0];
                nextCo = diffExt[WIDTH];
            end
            3'b010: nextF = bus.inM & bus.inN;
            3'b011: nextF = bus.inM | bus.inN;
            3'b100: nextF = bus.inM ^ bus.inN;
            3'b101: nextF = ~bus.inM;
            3'b110: begin
                nextF  = {bus.inM[WIDTH-2:0], bus.inC};
                nextCo = bus.inM[WIDTH-1];
            end
            // The reserved code and any unknown opcode both fall here. The
            // result is a clean zero, so a bad opcode spoils only one result.
            default: begin
                nextF  = '0;
                nextCo = 1'b0;
            end
        endcase
    end

    // The flags are computed from the same nextF that is being registered,
    // so they always agree with outF.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.outF <= '0;
            bus.zer  <= 1'b1;
            bus.neg  <= 1'b0;
            bus.co   <= 1'b0;
        end else begin
            bus.outF <= nextF;
            bus.zer  <= (nextF == '0);
            bus.neg  <= nextF[WIDTH-1];
            bus.co   <= nextCo;
        end
    end
endmodule

// File: tb/tb_alu16_reg.sv
// tb_alu16_reg: self-checking bench for alu16_reg. It uses directed
// boundary cases plus randomized back-to-back operations, and checks them
// against an arithmetic reference model.
module tb_alu16_reg;
    logic clk;
    logic rst_n;
    int   checkCount;
    int   errorCount;

    alu16_reg_if #(.WIDTH(16)) bus ();

    alu16_reg #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each scoreboard entry is {co, outF} expected for one sampled operation.
    logic [16:0] exp_q[$];

    task automatic checkVal(input string tag, input logic [31:0] got,
                            input logic [31:0] want);
        checkCount++;
        if (got !== want) begin
            errorCount++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, want);
        end
    endtask

    // Reference model. It works on unsigned integers, following the opcode
    // table directly.
    function automatic logic [16:0] refAlu(input logic [2:0] o, input int m,
                                           input int n, input int c);
        int r;
        logic cy;
        r  = 0;
        cy = 1'b0;
        case (o)
            3'd0: begin r = m + n + c; cy = (r > 65535); r = r % 65536; end
            3'd1: begin r = m - n - c; cy = (r < 0); if (r < 0) r = r + 65536; end
            3'd2: r = m & n;
            3'd3: r = m | n;
            3'd4: r = m ^ n;
            3'd5: r = 65535 - m;
            3'd6: begin r = (m * 2 + c) % 65536; cy = (m >= 32768); end
            default: r = 0;
        endcase
        return {cy, r[15:0]};
    endfunction

    // Driver: present one operation at the falling edge, so that it is
    // sampled at the next rising edge. The expected result goes into the
    // scoreboard; a reset cycle expects the reset values.
    task automatic drive(input logic rstVal, input logic [2:0] o,
                         input logic [15:0] m, input logic [15:0] n,
                         input logic c);
        @(negedge clk);
        rst_n   = rstVal;
        bus.opc = o;
        bus.inM = m;
        bus.inN = n;
        bus.inC = c;
        if (!rstVal) exp_q.push_back(17'h0);
        else         exp_q.push_back(refAlu(o, int'(m), int'(n), int'(c)));
        @(posedge clk);
        #1;
    endtask

    // Scoreboard check of the oldest expected entry against the outputs.
    task automatic checkOut(input string tag);
        logic [16:0] e;
        if (exp_q.size() == 0) begin
            checkVal({tag, "_queue"}, 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        checkVal({tag, "_outF"}, 32'(bus.outF), 32'(e[15:0]));
        checkVal({tag, "_zer"},  32'(bus.zer),  32'(e[15:0] == 16'h0));
        checkVal({tag, "_neg"},  32'(bus.neg),  32'(e[15]));
        checkVal({tag, "_co"},   32'(bus.co),   32'(e[16]));
    endtask

    task automatic doOp(input string tag, input logic [2:0] o,
                        input logic [15:0] m, input logic [15:0] n,
                        input logic c);
        drive(1'b1, o, m, n, c);
        checkOut(tag);
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        rst_n   = 1'b0;
        bus.inM = '0;
        bus.inN = '0;
        bus.opc = '0;
        bus.inC = 1'b0;

        // Reset: two cycles held low while an ADD is presented.
        drive(1'b0, 3'd0, 16'd5, 16'd4, 1'b0);
        checkOut("rst0");
        drive(1'b0, 3'd0, 16'd5, 16'd4, 1'b0);
        checkOut("rst1");
        doOp("rel_add", 3'd0, 16'd5, 16'd4, 1'b0);
        checkVal("rel_add_lit", 32'(bus.outF), 32'h9);

        // ADD
        doOp("add_wrap",  3'd0, 16'hFFFF, 16'h0001, 1'b0);
        doOp("add_cin",   3'd0, 16'hFFFF, 16'h0000, 1'b1);
        // SUB
        doOp("sub_zero",  3'd1, 16'd5, 16'd4, 1'b1);
        doOp("sub_neg",   3'd1, 16'd3, 16'd4, 1'b0);
        doOp("sub_bor",   3'd1, 16'h0000, 16'h0000, 1'b1);
        checkVal("sub_bor_lit", 32'(bus.outF), 32'hFFFF);

        // Logic operations
        doOp("and", 3'd2, 16'h0FF0, 16'h00FF, 1'b1);
        checkVal("and_lit", 32'(bus.outF), 32'h00F0);
        // Changing the inputs between edges must not reach the outputs.
        bus.inM = 16'hFFFF;
        bus.opc = 3'd3;
        #2;
        checkVal("no_comb_path", 32'(bus.outF), 32'h00F0);
        doOp("or",  3'd3, 16'h0FF0, 16'h00FF, 1'b0);
        doOp("xor", 3'd4, 16'h0FF0, 16'h00FF, 1'b1);
        doOp("not", 3'd5, 16'h0FF0, 16'h00FF, 1'b1);
        checkVal("not_lit", 32'(bus.outF), 32'hF00F);

        // Shift and reserved
        doOp("shl",  3'd6, 16'h8001, 16'h1234, 1'b1);
        checkVal("shl_lit", 32'(bus.outF), 32'h0003);
        doOp("rsv",  3'd7, 16'hBEEF, 16'hCAFE, 1'b1);

        // A reset asserted in mid-stream discards that cycle's operation.
        doOp("pre_mid", 3'd0, 16'h1234, 16'h1111, 1'b0);
        drive(1'b0, 3'd5, 16'h0000, 16'h0000, 1'b0);
        checkOut("mid_rst");

        // Randomized back-to-back operations, 10 for each of opcodes 0-6.
        for (int i = 0; i < 70; i++) begin
            doOp($sformatf("rnd%0d", i), 3'(i % 7),
                 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end
endmodule
